// File: rtl/fetch_unit.sv
// fetch_unit: program counter and 2-entry instruction prefetch queue
// for the 16-bit core, with branch redirect, fetch squash and halt.
module fetch_unit #(
    parameter int                 PC_W       = 12,
    parameter int                 INSTR_W    = 16,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hC0F0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               jflag,
    input  logic [PC_W-1:0]    jdest,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t state, state_nx;

    logic [PC_W-1:0]    fpc, fpc_nx;
    logic [PC_W-1:0]    addr, addr_nx;
    logic               req, req_nx;
    logic               squash, squash_nx;
    logic [1:0]         cnt, cnt_nx;
    logic [PC_W-1:0]    q0_pc, q1_pc;
    logic [INSTR_W-1:0] q0_in, q1_in;

    logic consume, taken, accept, hit_halt;
    logic flush, push, pop, outst;

    assign consume  = (cnt != 2'd0) & ~stall;
    assign taken    = consume & jflag;
    assign accept   = req & imem_ack & ~squash & ~taken & (state == RUN);
    assign hit_halt = consume & (q0_in == HALT_INSTR);
    assign flush    = taken | hit_halt;
    assign push     = accept & ~flush;
    assign pop      = consume & ~flush;
    assign outst    = req & ~imem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == RUN) & hit_halt: state_nx = HALT;
            default:                   state_nx = state;
        endcase
    end

    always_comb begin
        halted      = (state == HALT);
        instr_valid = (cnt != 2'd0);
        imem_req    = req;
        imem_addr   = addr;
        pc          = q0_pc;
        instr       = q0_in;
    end

    always_comb begin
        fpc_nx = fpc;
        if (taken)       fpc_nx = jdest;
        else if (accept) fpc_nx = fpc + PC_W'(1);

        if (flush) cnt_nx = 2'd0;
        else       cnt_nx = cnt + 2'(push) - 2'(pop);

        squash_nx = squash;
        if (req & imem_ack)  squash_nx = 1'b0;
        if (taken & outst)   squash_nx = 1'b1;

        // A pending request keeps its address even if fpc is redirected.
        req_nx  = outst | ((state_nx == RUN) & (cnt_nx <= 2'd1));
        addr_nx = outst ? addr : fpc_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            addr   <= RESET_PC;
            req    <= 1'b0;
            squash <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            fpc    <= fpc_nx;
            addr   <= addr_nx;
            req    <= req_nx;
            squash <= squash_nx;
            cnt    <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_pc <= '0;
            q0_in <= '0;
            q1_pc <= '0;
            q1_in <= '0;
        end else if (push) begin
            if (cnt == 2'd0 || (cnt == 2'd1 && pop)) begin
                q0_pc <= fpc;
                q0_in <= imem_rdata;
            end else if (cnt == 2'd1) begin
                q1_pc <= fpc;
                q1_in <= imem_rdata;
            end else begin
                q0_pc <= q1_pc;
                q0_in <= q1_in;
                q1_pc <= fpc;
                q1_in <= imem_rdata;
            end
        end else if (pop && cnt == 2'd2) begin
            q0_pc <= q1_pc;
            q0_in <= q1_in;
        end
    end

endmodule
